// File: rtl/alu_md.sv
// Execute-stage integer unit: XLEN-bit ALU plus RV M-extension multiply/divide.
// Simple ops finish in one cycle; multiplies take MUL_LAT cycles, divides XLEN+1.
module alu_md #(
  parameter int  XLEN    = 32,
  parameter int  MUL_LAT = 2,
  localparam int SHW     = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o,
  output logic [1:0]      dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_MULH = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV  = 5'd20;
  localparam logic [4:0] OP_DIVU = 5'd21;
  localparam logic [4:0] OP_REM  = 5'd22;
  localparam logic [4:0] OP_REMU = 5'd23;

  localparam int CW   = SHW + 1;
  localparam int NSTG = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] pipe_q [NSTG];
  logic [XLEN-1:0] pipe_d [NSTG];
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, is_rem_q, is_rem_d;

  // Handshake: an op transfers on a rising edge where valid_i & ready_o & ~flush_i;
  // ready_o is high only in IDLE, and valid_o is a one-cycle result strobe.
  logic accept;
  assign ready_o     = (state_q == ST_IDLE);
  assign stall_o     = ~ready_o;
  assign accept      = valid_i & ready_o & ~flush_i;
  assign valid_o     = valid_q;
  assign result_o    = result_q;
  assign dbg_state_o = state_q;

  logic is_mul, is_div, div_signed, div_zero, div_ovf;
  assign is_mul     = (op_i[4:2] == 3'b100);
  assign is_div     = (op_i[4:2] == 3'b101);
  assign div_signed = ~op_i[0];
  assign div_zero   = (op2_i == '0);
  assign div_ovf    = div_signed & (op1_i == MOST_NEG) & (op2_i == '1);

  // Full-width product: operands are extended to 2*XLEN per the op's signedness.
  logic              m_s1, m_s2;
  logic [2*XLEN-1:0] m_a, m_b, m_prod;
  logic [XLEN-1:0]   mul_res;
  always_comb begin
    m_s1    = (op_i[1:0] != 2'b11);
    m_s2    = ~op_i[1];
    m_a     = {{XLEN{m_s1 & op1_i[XLEN-1]}}, op1_i};
    m_b     = {{XLEN{m_s2 & op2_i[XLEN-1]}}, op2_i};
    m_prod  = m_a * m_b;
    mul_res = (op_i[1:0] == 2'b00) ? m_prod[XLEN-1:0] : m_prod[2*XLEN-1:XLEN];
  end

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] imm_res;
  always_comb begin
    shamt   = op2_i[SHW-1:0];
    imm_res = '0;
    case (op_i)
      OP_ADD:  imm_res = op1_i + op2_i;
      OP_SUB:  imm_res = op1_i - op2_i;
      OP_AND:  imm_res = op1_i & op2_i;
      OP_OR:   imm_res = op1_i | op2_i;
      OP_XOR:  imm_res = op1_i ^ op2_i;
      OP_SLL:  imm_res = op1_i << shamt;
      OP_SRL:  imm_res = op1_i >> shamt;
      OP_SRA:  imm_res = $signed(op1_i) >>> shamt;
      OP_SLT:  imm_res = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
      OP_SLTU: imm_res = {{(XLEN-1){1'b0}}, op1_i < op2_i};
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: imm_res = mul_res;
      // Only reached for divide-by-zero or signed overflow.
      OP_DIV, OP_DIVU: imm_res = div_zero ? '1 : op1_i;
      OP_REM, OP_REMU: imm_res = div_zero ? op1_i : '0;
      default: imm_res = '0;
    endcase
  end

  logic [XLEN-1:0] d_mag1, d_mag2;
  logic [XLEN:0]   d_shift, d_diff;
  logic            d_qbit;
  logic [XLEN-1:0] quo_nx, rem_nx, q_fin, r_fin;
  always_comb begin
    d_mag1  = (div_signed & op1_i[XLEN-1]) ? -op1_i : op1_i;
    d_mag2  = (div_signed & op2_i[XLEN-1]) ? -op2_i : op2_i;
    d_shift = {rem_q, quo_q[XLEN-1]};
    d_diff  = d_shift - {1'b0, dvs_q};
    d_qbit  = ~d_diff[XLEN];
    rem_nx  = d_qbit ? d_diff[XLEN-1:0] : d_shift[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], d_qbit};
    q_fin   = q_neg_q ? -quo_nx : quo_nx;
    r_fin   = r_neg_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    result_d = result_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_rem_d = is_rem_q;
    pipe_d[0] = mul_res;
    for (int i = 1; i < NSTG; i++) pipe_d[i] = pipe_q[i-1];
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul && (MUL_LAT > 1)) begin
            state_d = ST_MUL;
            cnt_d   = CW'(MUL_LAT - 1);
          end else if (is_div && !div_zero && !div_ovf) begin
            state_d  = ST_DIV;
            cnt_d    = CW'(XLEN);
            quo_d    = d_mag1;
            rem_d    = '0;
            dvs_d    = d_mag2;
            q_neg_d  = div_signed & (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
            r_neg_d  = div_signed & op1_i[XLEN-1];
            is_rem_d = op_i[1];
          end else begin
            valid_d  = 1'b1;
            result_d = imm_res;
          end
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          result_d = pipe_q[NSTG-1];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DIV: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          result_d = is_rem_q ? r_fin : q_fin;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      for (int i = 0; i < NSTG; i++) pipe_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
      for (int i = 0; i < NSTG; i++) pipe_q[i] <= pipe_d[i];
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md: a 32-bit/MUL_LAT=2 instance and a 64-bit/MUL_LAT=3 instance
// checked against an arithmetic reference model of the RV integer/M operations.
module tb_alu_md;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v32, f32, rdy32, vo32, st32;
  logic [4:0]  op32;
  logic [31:0] a32, b32, r32;
  logic [1:0]  ds32;
  logic        v64, f64, rdy64, vo64, st64;
  logic [4:0]  op64;
  logic [63:0] a64, b64, r64;
  logic [1:0]  ds64;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  alu_md #(.XLEN(32), .MUL_LAT(2)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(v32), .ready_o(rdy32), .op_i(op32),
    .op1_i(a32), .op2_i(b32), .flush_i(f32), .valid_o(vo32), .result_o(r32),
    .stall_o(st32), .dbg_state_o(ds32)
  );

  alu_md #(.XLEN(64), .MUL_LAT(3)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .valid_i(v64), .ready_o(rdy64), .op_i(op64),
    .op1_i(a64), .op2_i(b64), .flush_i(f64), .valid_o(vo64), .result_o(r64),
    .stall_o(st64), .dbg_state_o(ds64)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_res(input int xl, input logic [4:0] op,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, a, b, r;
    logic signed [127:0] sa, sb, ua, ub, p;
    int sh;
    m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a  = a_in & m;
    b  = b_in & m;
    ua = {64'd0, a};
    ub = {64'd0, b};
    sa = (xl == 64) ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
    sb = (xl == 64) ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
    sh = int'(b[5:0]) & (xl - 1);
    r  = '0;
    p  = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << sh;
      5'd6:  r = a >> sh;
      5'd7:  begin p = sa >>> sh; r = p[63:0]; end
      5'd8:  r = (sa < sb) ? 64'd1 : 64'd0;
      5'd9:  r = (a < b) ? 64'd1 : 64'd0;
      5'd16: begin p = sa * sb; r = p[63:0]; end
      5'd17: begin p = (sa * sb) >> xl; r = p[63:0]; end
      5'd18: begin p = (sa * ub) >> xl; r = p[63:0]; end
      5'd19: begin p = (ua * ub) >> xl; r = p[63:0]; end
      5'd20: if (b == 64'd0) r = m; else begin p = sa / sb; r = p[63:0]; end
      5'd21: if (b == 64'd0) r = m; else r = a / b;
      5'd22: if (b == 64'd0) r = a; else begin p = sa % sb; r = p[63:0]; end
      5'd23: if (b == 64'd0) r = a; else r = a % b;
      default: r = '0;
    endcase
    return r & m;
  endfunction

  function automatic int exp_lat(input int xl, input logic [4:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, mn, a, b;
    m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    a  = a_in & m;
    b  = b_in & m;
    if (op >= 5'd16 && op <= 5'd19) return (xl == 64) ? 3 : 2;
    if (op >= 5'd20 && op <= 5'd23) begin
      if (b == 64'd0) return 1;
      if ((op == 5'd20 || op == 5'd22) && a == mn && b == m) return 1;
      return xl + 1;
    end
    return 1;
  endfunction

  function automatic logic [63:0] rand_opnd(input int xl);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      3: v = 64'($urandom_range(0, 9));
      default: v = {$urandom, $urandom};
    endcase
    return (xl == 64) ? v : {32'd0, v[31:0]};
  endfunction

  // ---------------- DUT access / drivers ----------------
  function automatic logic valid_of(input int xl);
    return (xl == 64) ? vo64 : vo32;
  endfunction
  function automatic logic ready_of(input int xl);
    return (xl == 64) ? rdy64 : rdy32;
  endfunction
  function automatic logic stall_of(input int xl);
    return (xl == 64) ? st64 : st32;
  endfunction
  function automatic logic [63:0] res_of(input int xl);
    return (xl == 64) ? r64 : {32'd0, r32};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int xl, input logic v, input logic [4:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (xl == 64) begin v64 = v; op64 = op; a64 = a; b64 = b; end
    else begin v32 = v; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
  endtask

  // Offers one op, scrambles the inputs after acceptance, waits (bounded) for valid_o.
  task automatic issue_wait(input int xl, input logic [4:0] op, input logic [63:0] a,
                            input logic [63:0] b, output logic [63:0] got, output int lat,
                            output int stalls, output logic rdy, output logic seen);
    drive(xl, 1'b1, op, a, b);
    tick();
    drive(xl, 1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom}, {$urandom, $urandom});
    lat = 1;
    stalls = 0;
    while (!valid_of(xl) && lat < 200) begin
      if (stall_of(xl)) stalls++;
      tick();
      lat++;
    end
    seen = valid_of(xl);
    got  = res_of(xl);
    rdy  = ready_of(xl);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_vec++; if (rdy32 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", rdy32); end
    n_vec++; if (st32 !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", st32); end
    n_vec++; if (vo32 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", vo32); end
    n_vec++; if (r32 !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", r32); end
    n_vec++; if (r64 !== 64'd0 || rdy64 !== 1'b1) begin
      n_err++; $display("FAIL reset_64: got res %h rdy %b want 0/1", r64, rdy64);
    end
  endtask

  task automatic test_simple_b2b();
    logic [4:0]  ops[$];
    logic [63:0] as[$], bs[$];
    logic [W-1:0] want;
    int n;
    ops.push_back(5'd1); as.push_back(64'd5);          bs.push_back(64'd7);
    exp_q.push_back(64'hFFFF_FFFE);
    ops.push_back(5'd7); as.push_back(64'h8000_0000); bs.push_back(64'd4);
    exp_q.push_back(64'hF800_0000);
    ops.push_back(5'd9); as.push_back(64'd1);          bs.push_back(64'hFFFF_FFFF);
    exp_q.push_back(64'd1);
    for (int i = 0; i < 30; i++) begin
      ops.push_back(5'($urandom_range(0, 9)));
      as.push_back(rand_opnd(32));
      bs.push_back(rand_opnd(32));
      exp_q.push_back(ref_res(32, ops[$], as[$], bs[$]));
    end
    n = ops.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) drive(32, 1'b1, ops[i], as[i], bs[i]);
      else drive(32, 1'b0, 5'd0, 64'd0, 64'd0);
      if (i > 0) begin
        want = exp_q.pop_front();
        n_vec++; if (vo32 !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i-1, vo32); end
        n_vec++; if ({32'd0, r32} !== want) begin
          n_err++; $display("FAIL b2b_result[%0d] op %0d: got %h want %h", i-1, ops[i-1], r32, want);
        end
      end
      tick();
    end
    n_vec++; if (vo32 !== 1'b0) begin n_err++; $display("FAIL b2b_tail_valid: got %b want 0", vo32); end
  endtask

  task automatic test_mul();
    logic [4:0]  ops[$];
    logic [63:0] as[$], bs[$], wants[$];
    logic [63:0] got;
    int lat, stalls;
    logic rdy, seen;
    ops.push_back(5'd17); as.push_back(64'hFFFF_FFFF); bs.push_back(64'hFFFF_FFFF); wants.push_back(64'd0);
    ops.push_back(5'd19); as.push_back(64'hFFFF_FFFF); bs.push_back(64'hFFFF_FFFF); wants.push_back(64'hFFFF_FFFE);
    ops.push_back(5'd18); as.push_back(64'hFFFF_FFFE); bs.push_back(64'd3);         wants.push_back(64'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) begin
      ops.push_back(5'($urandom_range(16, 19)));
      as.push_back(rand_opnd(32));
      bs.push_back(rand_opnd(32));
      wants.push_back(ref_res(32, ops[$], as[$], bs[$]));
    end
    foreach (ops[i]) begin
      issue_wait(32, ops[i], as[i], bs[i], got, lat, stalls, rdy, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL mul_timeout[%0d]: got no valid_o want valid_o", i); end
      n_vec++; if (got !== wants[i]) begin
        n_err++; $display("FAIL mul_result[%0d] op %0d %h*%h: got %h want %h", i, ops[i], as[i], bs[i], got, wants[i]);
      end
      n_vec++; if (lat != 2 || stalls != 1 || rdy !== 1'b1) begin
        n_err++; $display("FAIL mul_timing[%0d]: got lat %0d stalls %0d rdy %b want 2/1/1", i, lat, stalls, rdy);
      end
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops[$];
    logic [63:0] as[$], bs[$], wants[$];
    logic [63:0] got;
    int lat, stalls, el;
    logic rdy, seen;
    ops.push_back(5'd20); as.push_back(64'hFFFF_FFF9); bs.push_back(64'd2); wants.push_back(64'hFFFF_FFFD);
    ops.push_back(5'd22); as.push_back(64'hFFFF_FFF9); bs.push_back(64'd2); wants.push_back(64'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) begin
      ops.push_back(5'($urandom_range(20, 23)));
      as.push_back(rand_opnd(32));
      bs.push_back({32'd0, $urandom} | 64'd1);
      wants.push_back(ref_res(32, ops[$], as[$], bs[$]));
    end
    foreach (ops[i]) begin
      el = exp_lat(32, ops[i], as[i], bs[i]);
      issue_wait(32, ops[i], as[i], bs[i], got, lat, stalls, rdy, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL div_timeout[%0d]: got no valid_o want valid_o", i); end
      n_vec++; if (got !== wants[i]) begin
        n_err++; $display("FAIL div_result[%0d] op %0d %h/%h: got %h want %h", i, ops[i], as[i], bs[i], got, wants[i]);
      end
      n_vec++; if (lat != el || stalls != el - 1 || rdy !== 1'b1) begin
        n_err++; $display("FAIL div_timing[%0d]: got lat %0d stalls %0d rdy %b want %0d/%0d/1", i, lat, stalls, rdy, el, el-1);
      end
    end
  endtask

  task automatic test_div_special();
    logic [4:0]  ops[5];
    logic [63:0] as[5], bs[5], wants[5];
    logic [63:0] got;
    int lat, stalls;
    logic rdy, seen;
    ops = '{5'd21, 5'd22, 5'd20, 5'd23, 5'd20};
    as  = '{64'h1234_5678, 64'h8000_0000, 64'h8000_0000, 64'hDEAD_BEEF, 64'h7};
    bs  = '{64'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 64'd0};
    wants = '{64'hFFFF_FFFF, 64'd0, 64'h8000_0000, 64'hDEAD_BEEF, 64'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      issue_wait(32, ops[i], as[i], bs[i], got, lat, stalls, rdy, seen);
      n_vec++; if (got !== wants[i] || !seen) begin
        n_err++; $display("FAIL divspec_result[%0d]: got %h valid %b want %h", i, got, seen, wants[i]);
      end
      n_vec++; if (lat != 1 || stalls != 0) begin
        n_err++; $display("FAIL divspec_timing[%0d]: got lat %0d stalls %0d want 1/0", i, lat, stalls);
      end
    end
  endtask

  task automatic test_undefined();
    logic [4:0] ops[4];
    logic [63:0] got;
    int lat, stalls;
    logic rdy, seen;
    ops = '{5'd10, 5'd15, 5'd24, 5'd31};
    for (int i = 0; i < 4; i++) begin
      issue_wait(32, 5'd0, 64'd40, 64'd2, got, lat, stalls, rdy, seen);
      issue_wait(32, ops[i], rand_opnd(32), rand_opnd(32), got, lat, stalls, rdy, seen);
      n_vec++; if (got !== 64'd0 || !seen || lat != 1) begin
        n_err++; $display("FAIL undef_op[%0d]: got %h valid %b lat %0d want 0/1/1", i, got, seen, lat);
      end
    end
  endtask

  task automatic test_random_all();
    logic [4:0] op;
    logic [63:0] a, b, got, want;
    int lat, stalls, el;
    logic rdy, seen;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      a = rand_opnd(32);
      b = rand_opnd(32);
      want = ref_res(32, op, a, b);
      el = exp_lat(32, op, a, b);
      issue_wait(32, op, a, b, got, lat, stalls, rdy, seen);
      n_vec++; if (got !== want || !seen || lat != el || stalls != el - 1) begin
        n_err++; $display("FAIL rand32[%0d] op %0d %h,%h: got %h lat %0d want %h lat %0d", i, op, a, b, got, lat, want, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(32, 1'b1, 5'd16, 64'd6, 64'd7);
    tick();
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0);
    n_vec++; if (rdy32 !== 1'b0) begin n_err++; $display("FAIL b2b_mul_busy: got ready %b want 0", rdy32); end
    tick();
    n_vec++; if (vo32 !== 1'b1 || r32 !== 32'd42 || rdy32 !== 1'b1) begin
      n_err++; $display("FAIL b2b_mul_done: got v %b r %h rdy %b want 1/2a/1", vo32, r32, rdy32);
    end
    drive(32, 1'b1, 5'd0, 64'd100, 64'd23);
    tick();
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0);
    n_vec++; if (vo32 !== 1'b1 || r32 !== 32'd123) begin
      n_err++; $display("FAIL b2b_add_after_mul: got v %b r %h want 1/7b", vo32, r32);
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int pulses;
    // Flush offered together with valid_i in IDLE: nothing accepted.
    drive(32, 1'b1, 5'd0, 64'd1, 64'd1);
    f32 = 1'b1;
    tick();
    f32 = 1'b0;
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0);
    n_vec++; if (vo32 !== 1'b0 || rdy32 !== 1'b1) begin
      n_err++; $display("FAIL flush_idle: got v %b rdy %b want 0/1", vo32, rdy32);
    end
    // Flush in the last MUL cycle suppresses the completion.
    prev = r32;
    drive(32, 1'b1, 5'd19, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    tick();
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0);
    f32 = 1'b1;
    tick();
    f32 = 1'b0;
    n_vec++; if (vo32 !== 1'b0 || rdy32 !== 1'b1 || r32 !== prev) begin
      n_err++; $display("FAIL flush_mul: got v %b rdy %b r %h want 0/1/%h", vo32, rdy32, r32, prev);
    end
    // Flush at t+10 of a DIV, then ADD accepted at t+11.
    drive(32, 1'b1, 5'd21, 64'd1000, 64'd7);
    tick();
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0);
    repeat (9) tick();
    f32 = 1'b1;
    tick();
    f32 = 1'b0;
    n_vec++; if (rdy32 !== 1'b1 || vo32 !== 1'b0) begin
      n_err++; $display("FAIL flush_div_idle: got rdy %b v %b want 1/0", rdy32, vo32);
    end
    drive(32, 1'b1, 5'd0, 64'd3, 64'd4);
    tick();
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0);
    n_vec++; if (vo32 !== 1'b1 || r32 !== 32'd7) begin
      n_err++; $display("FAIL flush_div_add: got v %b r %h want 1/7", vo32, r32);
    end
    pulses = 0;
    repeat (40) begin tick(); if (vo32 === 1'b1) pulses++; end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL flush_div_stray: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_reset_mid_div();
    logic [63:0] got;
    int lat, stalls, pulses;
    logic rdy, seen;
    issue_wait(32, 5'd0, 64'd1, 64'd2, got, lat, stalls, rdy, seen);
    drive(32, 1'b1, 5'd20, 64'hFFFF_FF00, 64'd3);
    tick();
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    n_vec++; if (rdy32 !== 1'b1 || st32 !== 1'b0 || vo32 !== 1'b0 || r32 !== 32'd0) begin
      n_err++; $display("FAIL reset_mid_div: got rdy %b stall %b v %b r %h want 1/0/0/0", rdy32, st32, vo32, r32);
    end
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin tick(); if (vo32 === 1'b1) pulses++; end
    n_vec++; if (pulses != 0 || rdy32 !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_div_after: got %0d pulses rdy %b want 0/1", pulses, rdy32);
    end
  endtask

  task automatic test_xlen64();
    logic [4:0] op;
    logic [63:0] a, b, got, want;
    int lat, stalls, el;
    logic rdy, seen;
    issue_wait(64, 5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, got, lat, stalls, rdy, seen);
    n_vec++; if (got !== 64'h5555_5555_5555_5555 || !seen) begin
      n_err++; $display("FAIL x64_divu: got %h valid %b want 5555555555555555", got, seen);
    end
    n_vec++; if (lat != 65 || stalls != 64) begin
      n_err++; $display("FAIL x64_divu_timing: got lat %0d stalls %0d want 65/64", lat, stalls);
    end
    for (int i = 0; i < 24; i++) begin
      op = 5'($urandom_range(0, 31));
      a = rand_opnd(64);
      b = rand_opnd(64);
      want = ref_res(64, op, a, b);
      el = exp_lat(64, op, a, b);
      issue_wait(64, op, a, b, got, lat, stalls, rdy, seen);
      n_vec++; if (got !== want || !seen || lat != el || stalls != el - 1) begin
        n_err++; $display("FAIL rand64[%0d] op %0d %h,%h: got %h lat %0d want %h lat %0d", i, op, a, b, got, lat, want, el);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    f32 = 1'b0;
    f64 = 1'b0;
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0);
    drive(64, 1'b0, 5'd0, 64'd0, 64'd0);
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_simple_b2b();
    test_mul();
    test_div();
    test_div_special();
    test_undefined();
    test_random_all();
    test_back_to_back();
    test_flush();
    test_reset_mid_div();
    test_xlen64();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage arithmetic unit: the single-cycle integer ALU generalised to XLEN bits and extended with the RV32M/RV64M multiply/divide operations. Simple ops complete in one cycle. Multiplies are pipelined over MUL_LAT cycles, and divides run as an XLEN-cycle restoring iteration. The unit sits between id_exe and exe_mem; it stalls the pipeline through ctrl while a multi-cycle op is in flight.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- MUL_LAT, 2, multiply latency in cycles; legal range is 1..4.
- SHW, $clog2(XLEN), derived shift-amount width; must not be overridden.
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  operation offered.
- ready_o  out  1  unit can accept an operation this cycle.
- op_i  in  5  opcodes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - MUL=16, MULH=17, MULHSU=18, MULHU=19.
  - DIV=20, DIVU=21, REM=22, REMU=23.
- op1_i  in  XLEN  rs1 operand.
- op2_i  in  XLEN  rs2 operand or immediate.
- flush_i  in  1  abort any in-flight operation.
- valid_o  out  1  one-cycle pulse; result_o is valid.
- result_o  out  XLEN  result.
- stall_o  out  1  equals ~ready_o; drives ctrl.

## Operation
- **Accept:** when valid_i & ready_o & ~flush_i. The unit latches op, operands and operand signs; the caller may change its inputs afterwards.
- **State machine:** IDLE, MUL, DIV.
  - ready_o=1 only in IDLE.
- **Simple ops (0..9):** result registered, no state change.
  - Shifts use op2[SHW-1:0].
  - SRA is arithmetic (sign-filled).
  - SLT is signed; SLTU is unsigned. Both return 0 or 1 zero-extended.
  - ADD and SUB wrap modulo 2^XLEN; no overflow flag.
- **MUL family:**
  - Form the full 2·XLEN product, with operands sign-extended per op:
    - MULH: signed × signed.
    - MULHSU: signed op1 × unsigned op2.
    - MULHU: unsigned × unsigned.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
  - The product passes through MUL_LAT-1 register stages.
  - If MUL_LAT==1, it completes like a simple op and MUL state is skipped.
  - Otherwise IDLE→MUL, with a counter loaded to MUL_LAT-1; MUL→IDLE when the counter reaches 1.
- **DIV family:**
  - Signed ops convert operands to magnitudes; the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
  - IDLE→DIV; XLEN restoring iterations, one quotient bit per cycle, with an SHW+1-bit counter.
  - DIV→IDLE after iteration XLEN; the result is sign-corrected and registered on that transition.
- **Divide special cases:** detected at accept, complete like a simple op, DIV state not entered.
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return op1.
  - Signed overflow (op1 = most-negative, op2 = -1): DIV returns op1; REM returns 0.
- **Undefined op_i:** completes like a simple op with result 0 and valid_o=1.
- **Flush:**
  - flush_i in MUL or DIV returns to IDLE next cycle; no valid_o for the aborted op.
  - flush_i with valid_i in IDLE: nothing accepted.
  - flush_i suppresses a valid_o that would otherwise assert next cycle.
- **Reset (asynchronous):**
  - State goes to IDLE and counters, pipeline stages and registers clear.
  - Outputs: ready_o=1, stall_o=0, valid_o=0, result_o=0.
  - Reset mid-operation discards the operation.

## Timing
- **Simple op** accepted in cycle t: valid_o and result_o in t+1. Back-to-back accepts give throughput 1/cycle.
- **MUL, MUL_LAT=L≥2,** accepted at t:
  - ready_o=0 during t+1..t+L-1.
  - valid_o at t+L, with ready_o=1 in that same cycle, so a new op can be accepted alongside the completion.
- **DIV** accepted at t:
  - ready_o=0 during t+1..t+XLEN.
  - valid_o and ready_o=1 at t+XLEN+1.
- **Special-case divide:** valid_o at t+1.
- valid_o is never asserted for two ops in the same cycle.
- result_o holds its last value between pulses.

## Test plan
- **Reset:** assert rst_i mid-DIV → outputs go to 0/IDLE immediately (asynchronously); no valid_o after release.
- **Simple ops, XLEN=32, back-to-back:**
  - SUB 5,7 → 0xFFFFFFFE at t+1.
  - SRA 0x80000000,4 → 0xF8000000.
  - SLTU 1,0xFFFFFFFF → 1.
  - One valid_o per cycle.
- **Multiply, MUL_LAT=2:**
  - MULH 0xFFFFFFFF,0xFFFFFFFF → 0.
  - MULHU same operands → 0xFFFFFFFE.
  - MULHSU -2,3 → 0xFFFFFFFF.
  - Each valid_o at t+2, with stall_o high only at t+1.
- **Divide:**
  - DIV -7,2 → -3 (0xFFFFFFFD) at t+33.
  - REM -7,2 → -1.
  - stall_o high for exactly 32 cycles.
- **Divide special cases:**
  - DIVU x/0 → 0xFFFFFFFF.
  - REM 0x80000000/-1 → 0.
  - DIV 0x80000000/-1 → 0x80000000.
  - All at t+1 with no stall.
- **Flush:**
  - flush_i at cycle t+10 of a DIV → IDLE at t+11 with no valid_o; a new ADD accepted at t+11 → result at t+12.
  - XLEN=64 regression: DIVU 2^64-1 by 3 → 0x5555555555555555 at t+65.
